// File: rtl/cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : cook_timer
// Description : Microwave cook controller. It counts down a mm:ss cook time,
//               pulses the magnetron on a power-slot duty cycle, pauses on
//               stop or an open door, and beeps for a fixed time when done.
// Revision    : 1.0 - initial release
// ============================================================================
module cook_timer #(
    parameter int SLOT_CYCLES = 6250000,
    parameter int BEEP_SECS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] time_minutes,
    input  logic [3:0] time_seconds,
    input  logic [2:0] power_level,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] remain_minutes,
    output logic [5:0] remain_seconds,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beep,
    output logic       busy
);

    localparam int c_cw = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int c_bw = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    localparam logic [c_cw-1:0] c_cnt_last  = c_cw'(SLOT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
    localparam logic [c_bw-1:0] c_beep_last = c_bw'(BEEP_SECS - 1);
    localparam logic [c_bw-1:0] c_beep_one  = c_bw'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]      r_state;
    logic [3:0]      r_min;
    logic [5:0]      r_sec;
    logic [2:0]      r_power;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_slot;
    logic [c_bw-1:0] r_beep_cnt;

    logic            w_tick;
    logic            w_prescale_on;
    logic [3:0]      w_add_min;
    logic [5:0]      w_add_sec;
    logic [3:0]      w_dec_min;
    logic [5:0]      w_dec_sec;
    logic            w_dec_zero;
    logic            w_load_ok;

    // One-second tick: last cycle of the last power slot
    assign w_tick        = (r_cnt == c_cnt_last) && (r_slot == 3'd7);
    assign w_prescale_on = (r_state == c_st_run) || (r_state == c_st_done);
    assign w_load_ok     = start && !stop && !door_open &&
                           ((time_minutes != 4'd0) || (time_seconds != 4'd0));

    // Remaining time plus 30 s, carrying into minutes and saturating at 15:59
    always_comb begin
        w_add_min = r_min;
        w_add_sec = r_sec;
        if (r_sec >= 6'd30) begin
            if (r_min == 4'd15) begin
                w_add_min = 4'd15;
                w_add_sec = 6'd59;
            end else begin
                w_add_min = r_min + 4'd1;
                w_add_sec = r_sec - 6'd30;
            end
        end else begin
            w_add_sec = r_sec + 6'd30;
        end
    end

    // Remaining time minus one second, borrowing from minutes
    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec - 6'd1;
        if (r_sec == 6'd0) begin
            w_dec_min = r_min - 4'd1;
            w_dec_sec = 6'd59;
        end
        w_dec_zero = (w_dec_min == 4'd0) && (w_dec_sec == 6'd0);
    end

    // Main controller: state, remaining time, latched power, prescaler, beep count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_min      <= 4'd0;
            r_sec      <= 6'd0;
            r_power    <= 3'd0;
            r_cnt      <= '0;
            r_slot     <= 3'd0;
            r_beep_cnt <= '0;
        end else begin
            // Prescaler free-runs only in RUN/DONE; it sits at zero elsewhere,
            // so every entry into RUN from IDLE/PAUSE starts a fresh second.
            if (w_prescale_on) begin
                if (r_cnt == c_cnt_last) begin
                    r_cnt  <= '0;
                    r_slot <= r_slot + 3'd1;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else begin
                r_cnt  <= '0;
                r_slot <= 3'd0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_load_ok) begin
                        r_min   <= time_minutes;
                        r_sec   <= {2'b00, time_seconds};
                        r_power <= power_level;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (stop || door_open) begin
                        r_state <= c_st_pause;
                    end else if (start) begin
                        // The add wins over a coincident tick: no decrement
                        r_min <= w_add_min;
                        r_sec <= w_add_sec;
                    end else if (w_tick) begin
                        r_min <= w_dec_min;
                        r_sec <= w_dec_sec;
                        if (w_dec_zero) begin
                            r_state    <= c_st_done;
                            r_cnt      <= '0;
                            r_slot     <= 3'd0;
                            r_beep_cnt <= '0;
                        end
                    end
                end
                c_st_pause: begin
                    if (stop) begin
                        r_min   <= 4'd0;
                        r_sec   <= 6'd0;
                        r_state <= c_st_idle;
                    end else if (start && !door_open) begin
                        r_state <= c_st_run;
                    end
                end
                default: begin
                    if (stop || door_open) begin
                        r_state <= c_st_idle;
                    end else if (w_tick) begin
                        if (r_beep_cnt == c_beep_last) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_beep_cnt <= r_beep_cnt + c_beep_one;
                        end
                    end
                end
            endcase
        end
    end

    // Door gating is combinational so the magnetron drops in the same cycle;
    // the state term comes from an async-reset register, so rst drops it too.
    assign magnetron_on   = (r_state == c_st_run) && (r_slot <= r_power) && !door_open;
    assign lamp_on        = (r_state == c_st_run) || door_open;
    assign beep           = (r_state == c_st_done);
    assign busy           = (r_state == c_st_run) || (r_state == c_st_pause);
    assign remain_minutes = r_min;
    assign remain_seconds = r_sec;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cook_timer
// Description : Scoreboard bench for cook_timer. Stimulus pushes expected
//               output values tagged with the cycle they must appear in; a
//               monitor pops and compares them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_timer;

    localparam int c_sig_min  = 0;
    localparam int c_sig_sec  = 1;
    localparam int c_sig_mag  = 2;
    localparam int c_sig_lamp = 3;
    localparam int c_sig_beep = 4;
    localparam int c_sig_busy = 5;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] time_minutes;
    logic [3:0] time_seconds;
    logic [2:0] power_level;
    logic       start;
    logic       stop;
    logic       door_open;
    logic [3:0] remain_minutes;
    logic [5:0] remain_seconds;
    logic       magnetron_on;
    logic       lamp_on;
    logic       beep;
    logic       busy;

    int   cyc;
    int   total;
    int   bad;
    exp_t q[$];
    exp_t e;
    int   act;
    int   b;

    cook_timer #(
        .SLOT_CYCLES (2),
        .BEEP_SECS   (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .time_minutes   (time_minutes),
        .time_seconds   (time_seconds),
        .power_level    (power_level),
        .start          (start),
        .stop           (stop),
        .door_open      (door_open),
        .remain_minutes (remain_minutes),
        .remain_seconds (remain_seconds),
        .magnetron_on   (magnetron_on),
        .lamp_on        (lamp_on),
        .beep           (beep),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sel(input int s);
        case (s)
            c_sig_min:  return int'(remain_minutes);
            c_sig_sec:  return int'(remain_seconds);
            c_sig_mag:  return int'(magnetron_on);
            c_sig_lamp: return int'(lamp_on);
            c_sig_beep: return int'(beep);
            default:    return int'(busy);
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input int v, input string n);
        exp_t x;
        x.cyc  = c;
        x.sig  = s;
        x.val  = v;
        x.name = n;
        q.push_back(x);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = sel(e.sig);
            total++;
            if (e.cyc != cyc || act != e.val) begin
                bad++;
                $display("FAIL %s cyc=%0d due=%0d got=%0d want=%0d",
                         e.name, cyc, e.cyc, act, e.val);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; door_open = 1'b0;
        time_minutes = 4'd0; time_seconds = 4'd0; power_level = 3'd0;

        // Reset state; lamp follows the door even under reset
        goto(2);
        expect_at(2, c_sig_busy, 0, "rst_busy");
        expect_at(2, c_sig_min,  0, "rst_min");
        expect_at(2, c_sig_sec,  0, "rst_sec");
        expect_at(2, c_sig_mag,  0, "rst_mag");
        expect_at(2, c_sig_beep, 0, "rst_beep");
        door_open = 1'b1;
        expect_at(2, c_sig_lamp, 1, "rst_lamp_door");
        goto(3);
        door_open = 1'b0;
        expect_at(3, c_sig_lamp, 0, "rst_lamp_closed");
        rst = 1'b0;
        goto(4);

        // 0:02 at power 7: full run, done, 48-cycle beep, back to idle
        b = cyc;
        time_minutes = 4'd0; time_seconds = 4'd2; power_level = 3'd7; start = 1'b1;
        expect_at(b, c_sig_busy, 0, "t1_idle_before");
        goto(b + 1);
        start = 1'b0;
        time_seconds = 4'd9;  // must not affect the running count
        expect_at(b + 1,  c_sig_busy, 1, "t1_run_busy");
        expect_at(b + 1,  c_sig_mag,  1, "t1_mag_on");
        expect_at(b + 1,  c_sig_lamp, 1, "t1_lamp_on");
        expect_at(b + 1,  c_sig_sec,  2, "t1_sec_load");
        expect_at(b + 8,  c_sig_mag,  1, "t1_mag_mid");
        expect_at(b + 16, c_sig_sec,  2, "t1_sec_pre_tick");
        expect_at(b + 17, c_sig_sec,  1, "t1_sec_tick1");
        expect_at(b + 17, c_sig_mag,  1, "t1_mag_after_tick");
        expect_at(b + 32, c_sig_busy, 1, "t1_busy_pre_done");
        expect_at(b + 33, c_sig_beep, 1, "t1_beep_on");
        expect_at(b + 33, c_sig_busy, 0, "t1_done_busy");
        expect_at(b + 33, c_sig_sec,  0, "t1_done_sec");
        expect_at(b + 33, c_sig_mag,  0, "t1_done_mag");
        expect_at(b + 80, c_sig_beep, 1, "t1_beep_last");
        expect_at(b + 81, c_sig_beep, 0, "t1_beep_off");
        expect_at(b + 81, c_sig_busy, 0, "t1_idle_after");
        goto(b + 82);

        // Power 1: on for slots 0-1 (4 of 16 cycles); then stop, stop -> idle
        b = cyc;
        time_minutes = 4'd0; time_seconds = 4'd5; power_level = 3'd1; start = 1'b1;
        goto(b + 1);
        start = 1'b0;
        power_level = 3'd7;  // ignored until the next load
        expect_at(b + 1,  c_sig_mag, 1, "p1_slot0");
        expect_at(b + 4,  c_sig_mag, 1, "p1_slot1");
        expect_at(b + 5,  c_sig_mag, 0, "p1_slot2");
        expect_at(b + 16, c_sig_mag, 0, "p1_slot7");
        expect_at(b + 17, c_sig_mag, 1, "p1_wrap");
        expect_at(b + 17, c_sig_sec, 4, "p1_tick");
        goto(b + 17);
        stop = 1'b1;
        goto(b + 18);
        expect_at(b + 18, c_sig_busy, 1, "p1_pause_busy");
        expect_at(b + 18, c_sig_mag,  0, "p1_pause_mag");
        expect_at(b + 18, c_sig_sec,  4, "p1_pause_held");
        goto(b + 19);
        stop = 1'b0;
        expect_at(b + 19, c_sig_busy, 0, "p1_stop_idle");
        expect_at(b + 19, c_sig_sec,  0, "p1_stop_clr_sec");
        expect_at(b + 19, c_sig_min,  0, "p1_stop_clr_min");

        // Power 0: on for slot 0 only (2 of 16 cycles)
        b = cyc;
        time_seconds = 4'd5; power_level = 3'd0; start = 1'b1;
        goto(b + 1);
        start = 1'b0;
        expect_at(b + 1,  c_sig_mag, 1, "p0_slot0a");
        expect_at(b + 2,  c_sig_mag, 1, "p0_slot0b");
        expect_at(b + 3,  c_sig_mag, 0, "p0_slot1");
        expect_at(b + 16, c_sig_mag, 0, "p0_slot7");
        expect_at(b + 17, c_sig_mag, 1, "p0_wrap");
        goto(b + 17);
        stop = 1'b1;
        goto(b + 19);
        stop = 1'b0;

        // 1:00 -> 0:59 borrow; start on a tick cycle adds 30 s with no decrement
        b = cyc;
        time_minutes = 4'd1; time_seconds = 4'd0; power_level = 3'd7; start = 1'b1;
        goto(b + 1);
        start = 1'b0;
        expect_at(b + 16, c_sig_min, 1,  "bor_min_pre");
        expect_at(b + 16, c_sig_sec, 0,  "bor_sec_pre");
        expect_at(b + 17, c_sig_min, 0,  "bor_min");
        expect_at(b + 17, c_sig_sec, 59, "bor_sec");
        goto(b + 32);
        start = 1'b1;
        goto(b + 33);
        start = 1'b0;
        stop  = 1'b1;
        expect_at(b + 33, c_sig_min, 1,  "add_carry_min");
        expect_at(b + 33, c_sig_sec, 29, "add_carry_sec");
        expect_at(b + 34, c_sig_sec, 29, "add_pause_held");
        goto(b + 35);
        stop = 1'b0;

        // 15:15 + 30 -> 15:45, + 30 -> 15:59 saturated
        b = cyc;
        time_minutes = 4'd15; time_seconds = 4'd15; start = 1'b1;
        goto(b + 1);
        expect_at(b + 2, c_sig_min, 15, "sat_min_a");
        expect_at(b + 2, c_sig_sec, 45, "sat_sec_a");
        expect_at(b + 3, c_sig_min, 15, "sat_min_b");
        expect_at(b + 3, c_sig_sec, 59, "sat_sec_b");
        goto(b + 3);
        start = 1'b0;
        stop  = 1'b1;
        goto(b + 5);
        stop = 1'b0;
        expect_at(b + 5, c_sig_busy, 0, "sat_idle");

        // 0:15 + 30 -> 0:45; start+stop together -> pause without add
        b = cyc;
        time_minutes = 4'd0; time_seconds = 4'd15; start = 1'b1;
        goto(b + 1);
        expect_at(b + 2, c_sig_sec, 45, "ss_add");
        goto(b + 2);
        stop = 1'b1;
        expect_at(b + 3, c_sig_busy, 1,  "ss_pause_busy");
        expect_at(b + 3, c_sig_mag,  0,  "ss_pause_mag");
        expect_at(b + 3, c_sig_sec,  45, "ss_no_add_sec");
        expect_at(b + 3, c_sig_min,  0,  "ss_no_add_min");
        expect_at(b + 4, c_sig_busy, 0,  "ss_pause_stop_wins");
        goto(b + 4);
        start = 1'b0;
        stop  = 1'b0;

        // Door: immediate magnetron cut, pause, start ignored while open, resume
        b = cyc;
        time_minutes = 4'd0; time_seconds = 4'd10; power_level = 3'd7; start = 1'b1;
        goto(b + 1);
        start = 1'b0;
        goto(b + 3);
        door_open = 1'b1;
        expect_at(b + 3, c_sig_mag,  0,  "door_mag_same_cycle");
        expect_at(b + 3, c_sig_lamp, 1,  "door_lamp");
        expect_at(b + 4, c_sig_busy, 1,  "door_pause_busy");
        expect_at(b + 4, c_sig_sec,  10, "door_pause_held");
        goto(b + 4);
        start = 1'b1;
        goto(b + 5);
        start = 1'b0;
        goto(b + 6);
        door_open = 1'b0;
        expect_at(b + 6, c_sig_lamp, 0, "door_start_ignored");
        expect_at(b + 6, c_sig_busy, 1, "door_still_paused");
        start = 1'b1;
        goto(b + 7);
        start = 1'b0;
        expect_at(b + 7, c_sig_mag,  1,  "door_resume_mag");
        expect_at(b + 7, c_sig_lamp, 1,  "door_resume_lamp");
        expect_at(b + 7, c_sig_sec,  10, "door_resume_sec");

        // Asynchronous reset mid-RUN, off the clock edge
        goto(b + 9);
        #2;
        rst = 1'b1;
        expect_at(b + 9, c_sig_mag,  0, "arst_mag");
        expect_at(b + 9, c_sig_busy, 0, "arst_busy");
        expect_at(b + 9, c_sig_beep, 0, "arst_beep");
        expect_at(b + 9, c_sig_lamp, 0, "arst_lamp");
        expect_at(b + 9, c_sig_sec,  0, "arst_sec");
        expect_at(b + 9, c_sig_min,  0, "arst_min");
        goto(b + 10);
        rst = 1'b0;

        // Start with 0:00 is ignored
        b = cyc;
        time_minutes = 4'd0; time_seconds = 4'd0; start = 1'b1;
        goto(b + 1);
        start = 1'b0;
        expect_at(b + 1, c_sig_busy, 0, "zero_start_idle");
        expect_at(b + 1, c_sig_lamp, 0, "zero_start_lamp");

        goto(cyc + 2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 SHALL have parameter: SLOT_CYCLES, 6250000, clk cycles per power slot (8 slots = 1 s at 50 MHz).
REQ-002 SHALL have parameter: BEEP_SECS, 3, seconds the done beep lasts.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: time_minutes  input  4  set minutes from keypad interface, 0-15.
REQ-006 SHALL have port: time_seconds  input  4  set seconds from keypad interface, 0-15.
REQ-007 SHALL have port: power_level  input  3  set power, 0 (12.5%) to 7 (100%).
REQ-008 SHALL have ports: start, stop  input  1 each  single-cycle command pulses.
REQ-009 SHALL have port: door_open  input  1  level, 1 = door open.
REQ-010 SHALL have port: remain_minutes  output  4  minutes remaining.
REQ-011 SHALL have port: remain_seconds  output  6  seconds remaining, 0-59.
REQ-012 SHALL have ports: magnetron_on, lamp_on, beep, busy  output  1 each.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE; busy = 1 in RUN or PAUSE.
REQ-014 Prescaler SHALL count cycles 0..SLOT_CYCLES-1 and a 3-bit slot index; second tick = last cycle of slot 7.
REQ-015 Prescaler SHALL run only in RUN and DONE and SHALL clear to 0 on every entry to RUN or DONE.
REQ-016 IDLE: start with door_open=0 and (time_minutes, time_seconds) != (0,0) SHALL load remain = inputs, latch power_level, and enter RUN next cycle; otherwise start is ignored.
REQ-017 RUN: each second tick SHALL decrement remain: seconds 0 -> 59 with minutes-1, else seconds-1.
REQ-018 RUN: the tick that makes remain 0:00 SHALL enter DONE.
REQ-019 RUN: start SHALL add 30 s (carry into minutes at 60), saturating at 15:59; the add takes precedence over a same-cycle tick decrement.
REQ-020 RUN: stop or door_open SHALL enter PAUSE next cycle, remain held.
REQ-021 PAUSE: start with door_open=0 SHALL resume RUN with remain and latched power unchanged; stop SHALL clear remain to 0:00 and enter IDLE.
REQ-022 DONE: beep = 1; after BEEP_SECS second ticks, or on stop or door_open, SHALL enter IDLE.
REQ-023 Same-cycle start and stop: stop SHALL win in every state.
REQ-024 magnetron_on SHALL = (state==RUN) and (slot index <= latched power) and not door_open, with door_open gating combinational (off in the same cycle).
REQ-025 lamp_on SHALL = (state==RUN) or door_open.
REQ-026 Inputs time_*/power_level SHALL be sampled only at the IDLE start; later changes have no effect until the next load.

Reset
REQ-027 rst SHALL asynchronously force IDLE, remain 0:00, latched power 0, prescaler 0, and magnetron_on, beep, busy = 0; lamp_on then = door_open.
REQ-028 rst asserted mid-RUN SHALL drop magnetron_on immediately, without waiting for a clock edge.

Verification (SLOT_CYCLES=2, BEEP_SECS=3: 1 s = 16 cycles)
REQ-029 Load 0:02 power 7, start -> RUN, magnetron_on constant 1, 0:01 after 16 cycles, DONE after 32, beep for 48 cycles, then IDLE.
REQ-030 Power 1, RUN -> magnetron_on high 4 of every 16 cycles (slots 0-1); power 0 -> 2 of 16.
REQ-031 Remain 1:00, tick -> 0:59; remain 15:45, start -> 15:59 (saturated); start plus stop in the same cycle -> PAUSE, no add.
REQ-032 door_open mid-RUN -> magnetron_on 0 in the same cycle, PAUSE, remain held; start while the door is open is ignored; after door close, start resumes.
REQ-033 IDLE start with 0:00 -> stays IDLE; PAUSE stop -> IDLE, remain 0:00.
REQ-034 rst asserted mid-RUN, asynchronously off-edge -> all outputs to their reset values before the next clk edge.
